// File: rtl/sync_event_arbiter.sv
// rtl/sync_event_arbiter.sv - round-robin arbiter sharing one clkA->clkB pulse synchronizer among N_REQ event sources
// Optional watchdog on the busy handshake: define SYNC_ARB_TIMEOUT_EN.
module sync_event_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clkA,
    input  logic              rstB,
    input  logic [N_REQ-1:0]  evt_in,
    input  logic              sync_busy,
    input  logic [N_REQ-1:0]  ovf_clr,
    output logic              sync_pulse,
    output logic [ID_W-1:0]   sync_id,
    output logic [N_REQ-1:0]  pending,
    output logic [N_REQ-1:0]  ovf,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (N_REQ < 2 || N_REQ > 8 || (1 << ID_W) < N_REQ || TIMEOUT < 1) begin : g_cfg_check
        $error("sync_event_arbiter: illegal parameter combination");
    end

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt [N_REQ];
    logic [N_REQ-1:0]  nz;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   win;
    logic              found;
    logic              grant_any;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            nz[i] = (cnt[i] != '0);
        end
    end

    assign pending = nz;

    // Rotating search starting just after the last winner; constant indices keep it a flat mux tree.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && nz[j] && (j == (int'(ptr) + k) % N_REQ)) begin
                    found = 1'b1;
                    win   = ID_W'(j);
                end
            end
        end
    end

    assign grant_any = (state == IDLE) && !sync_busy && found;

    always_comb begin
        for (int j = 0; j < N_REQ; j++) begin
            grant[j] = grant_any && (win == ID_W'(j));
        end
    end

    always_ff @(posedge clkA) begin
        if (rstB) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (evt_in[i] && !grant[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        ovf[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                        if (ovf_clr[i]) begin
                            ovf[i] <= 1'b0;
                        end
                    end
                end else begin
                    if (grant[i] && !evt_in[i]) begin
                        cnt[i] <= cnt[i] - 1'b1;
                    end
                    if (ovf_clr[i]) begin
                        ovf[i] <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef SYNC_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clkA) begin
        if (rstB) begin
            state      <= IDLE;
            sync_pulse <= 1'b0;
            sync_id    <= '0;
            ptr        <= ID_W'(N_REQ - 1);
`ifdef SYNC_ARB_TIMEOUT_EN
            wd          <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            sync_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        ptr        <= win;
                        sync_id    <= win;
                        sync_pulse <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_ACK;
`ifdef SYNC_ARB_TIMEOUT_EN
                    wd    <= '0;
`endif
                end
                WAIT_ACK: begin
                    if (sync_busy) begin
                        state <= WAIT_DONE;
`ifdef SYNC_ARB_TIMEOUT_EN
                    // The granted event stays consumed; the channel is simply released.
                    end else if (wd == WD_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd <= wd + 1'b1;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (!sync_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_event_arbiter.sv
// tb/tb_sync_event_arbiter.sv - directed vector bench for sync_event_arbiter with a busy-pulse synchronizer model
module tb_sync_event_arbiter;

    logic       clkA = 1'b0;
    logic       rstB = 1'b1;
    logic [3:0] evt_in = '0;
    logic [3:0] ovf_clr = '0;
    logic       sync_busy;
    logic       sync_pulse;
    logic [1:0] sync_id;
    logic [3:0] pending;
    logic [3:0] ovf;
    logic       timeout_err;

    logic       hold_busy = 1'b0;
    logic       model_en = 1'b1;
    int         busy_cnt = 0;

    int total = 0;
    int bad = 0;

    logic [1:0] pulse_ids [$];

    typedef struct {
        logic [3:0] evt;
        logic [3:0] clr;
        logic [3:0] exp_pend;
        logic [3:0] exp_ovf;
    } vec_t;

    vec_t vecs [5];

    sync_event_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(4), .TIMEOUT(16)) dut (
        .clkA        (clkA),
        .rstB        (rstB),
        .evt_in      (evt_in),
        .sync_busy   (sync_busy),
        .ovf_clr     (ovf_clr),
        .sync_pulse  (sync_pulse),
        .sync_id     (sync_id),
        .pending     (pending),
        .ovf         (ovf),
        .timeout_err (timeout_err)
    );

    always #5 clkA = ~clkA;

    // Synchronizer model: busy for 6 cycles starting the cycle after the pulse.
    always @(posedge clkA) begin
        if (model_en && sync_pulse) busy_cnt <= 6;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    assign sync_busy = hold_busy | (busy_cnt != 0);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: pulse log, single-cycle pulse, id stability under busy, spacing after busy falls.
    int   cyc = 0;
    int   fall_cyc = 0;
    logic fall_valid = 1'b0;
    logic arm = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_pulse = 1'b0;
    logic prev_rst = 1'b1;
    logic [1:0] prev_id = '0;

    always @(posedge clkA) begin
        #1;
        cyc++;
        if (rstB) begin
            arm = 1'b0;
            fall_valid = 1'b0;
        end else begin
            if (sync_pulse) begin
                pulse_ids.push_back(sync_id);
                chk("pulse_width", int'(prev_pulse), 0);
                if (fall_valid) chk("pulse_spacing", int'((cyc - fall_cyc) >= 2), 1);
                arm = 1'b1;
                fall_valid = 1'b0;
            end
            if (sync_busy && prev_busy && !prev_rst) chk("id_stable_busy", int'(sync_id), int'(prev_id));
            if (!sync_busy && prev_busy && arm) begin
                fall_cyc = cyc;
                fall_valid = 1'b1;
                arm = 1'b0;
            end
        end
        prev_busy = sync_busy;
        prev_pulse = sync_pulse;
        prev_rst = rstB;
        prev_id = sync_id;
    end

    task automatic do_reset();
        rstB = 1'b1;
        repeat (2) @(negedge clkA);
        rstB = 1'b0;
    endtask

    task automatic wait_pulse(input string name, input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            if (sync_pulse) break;
            @(negedge clkA);
        end
        chk(name, int'(sync_pulse), 1);
    endtask

    initial begin
        vecs[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
        vecs[1] = '{4'b0100, 4'b0000, 4'b0101, 4'b0000};
        vecs[2] = '{4'b0000, 4'b1111, 4'b0101, 4'b0000};
        vecs[3] = '{4'b1010, 4'b0000, 4'b1111, 4'b0000};
        vecs[4] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000};

        repeat (3) @(negedge clkA);
        rstB = 1'b0;
        @(negedge clkA);
        chk("rst_pulse", int'(sync_pulse), 0);
        chk("rst_id", int'(sync_id), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_timeout", int'(timeout_err), 0);

        // Single event, single transfer.
        pulse_ids.delete();
        evt_in = 4'b0001;
        @(negedge clkA);
        evt_in = '0;
        chk("t1_pend_reg", int'(pending), 1);
        chk("t1_no_pulse_yet", int'(sync_pulse), 0);
        @(negedge clkA);
        chk("t1_pulse", int'(sync_pulse), 1);
        chk("t1_id", int'(sync_id), 0);
        chk("t1_pend_grant", int'(pending), 0);
        @(negedge clkA);
        chk("t1_pulse_end", int'(sync_pulse), 0);
        repeat (20) @(negedge clkA);
        chk("t1_count", pulse_ids.size(), 1);

        // Counter vectors with the channel blocked; ptr is 0 so drain order is 1,2,3,0.
        pulse_ids.delete();
        hold_busy = 1'b1;
        for (int v = 0; v < 5; v++) begin
            evt_in = vecs[v].evt;
            ovf_clr = vecs[v].clr;
            @(negedge clkA);
            evt_in = '0;
            ovf_clr = '0;
            chk($sformatf("vec%0d_pend", v), int'(pending), int'(vecs[v].exp_pend));
            chk($sformatf("vec%0d_ovf", v), int'(ovf), int'(vecs[v].exp_ovf));
            chk($sformatf("vec%0d_nopulse", v), int'(sync_pulse), 0);
        end
        hold_busy = 1'b0;
        repeat (50) @(negedge clkA);
        chk("vec_drain_count", pulse_ids.size(), 4);
        if (pulse_ids.size() == 4) begin
            chk("vec_drain_id0", int'(pulse_ids[0]), 1);
            chk("vec_drain_id1", int'(pulse_ids[1]), 2);
            chk("vec_drain_id2", int'(pulse_ids[2]), 3);
            chk("vec_drain_id3", int'(pulse_ids[3]), 0);
        end

        // All four requesters in one cycle from reset: order 0,1,2,3.
        do_reset();
        pulse_ids.delete();
        evt_in = 4'b1111;
        @(negedge clkA);
        evt_in = '0;
        repeat (50) @(negedge clkA);
        chk("rr_count", pulse_ids.size(), 4);
        for (int k = 0; k < 4 && k < pulse_ids.size(); k++) begin
            chk($sformatf("rr_id%0d", k), int'(pulse_ids[k]), k);
        end
        chk("rr_pend_empty", int'(pending), 0);

        // Saturation of requester 2.
        pulse_ids.delete();
        hold_busy = 1'b1;
        repeat (20) begin
            evt_in = 4'b0100;
            @(negedge clkA);
        end
        evt_in = '0;
        @(negedge clkA);
        chk("sat_pend", int'(pending), 4);
        chk("sat_ovf", int'(ovf), 4);
        evt_in = 4'b0100;
        ovf_clr = 4'b0100;
        @(negedge clkA);
        evt_in = '0;
        ovf_clr = '0;
        chk("sat_set_wins", int'(ovf), 4);
        hold_busy = 1'b0;
        repeat (160) @(negedge clkA);
        chk("sat_count", pulse_ids.size(), 15);
        begin
            int wrong = 0;
            foreach (pulse_ids[k]) if (pulse_ids[k] != 2'd2) wrong++;
            chk("sat_ids_all_2", wrong, 0);
        end
        chk("sat_ovf_kept", int'(ovf), 4);
        ovf_clr = 4'b0100;
        @(negedge clkA);
        ovf_clr = '0;
        chk("sat_ovf_clr", int'(ovf), 0);

        // Event coinciding with a grant to the same requester.
        pulse_ids.delete();
        hold_busy = 1'b1;
        evt_in = 4'b0010;
        @(negedge clkA);
        evt_in = '0;
        chk("same_pre_pend", int'(pending), 2);
        hold_busy = 1'b0;
        evt_in = 4'b0010;
        @(negedge clkA);
        evt_in = '0;
        chk("same_pulse", int'(sync_pulse), 1);
        chk("same_id", int'(sync_id), 1);
        chk("same_pend_kept", int'(pending), 2);
        repeat (30) @(negedge clkA);
        chk("same_count", pulse_ids.size(), 2);
        chk("same_pend_done", int'(pending), 0);

        // Reset during WAIT_DONE with busy still high.
        pulse_ids.delete();
        evt_in = 4'b0001;
        @(negedge clkA);
        evt_in = '0;
        wait_pulse("mid_first_pulse", 10);
        @(negedge clkA);
        evt_in = 4'b0010;
        @(negedge clkA);
        evt_in = '0;
        @(negedge clkA);
        rstB = 1'b1;
        @(negedge clkA);
        rstB = 1'b0;
        chk("mid_rst_pulse", int'(sync_pulse), 0);
        chk("mid_rst_id", int'(sync_id), 0);
        chk("mid_rst_pend", int'(pending), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        evt_in = 4'b0100;
        @(negedge clkA);
        evt_in = '0;
        chk("mid_held_pend", int'(pending), 4);
        chk("mid_held_nopulse", int'(sync_pulse), 0);
        @(negedge clkA);
        wait_pulse("mid_second_pulse", 20);
        chk("mid_second_id", int'(sync_id), 2);
        chk("mid_busy_low_at_issue", int'(sync_busy), 0);
        repeat (30) @(negedge clkA);
        chk("mid_count", pulse_ids.size(), 2);

`ifdef SYNC_ARB_TIMEOUT_EN
        // Watchdog: busy never rises.
        model_en = 1'b0;
        evt_in = 4'b0011;
        @(negedge clkA);
        evt_in = '0;
        wait_pulse("to_first_pulse", 10);
        chk("to_first_id", int'(sync_id), 0);
        repeat (16) @(negedge clkA);
        chk("to_not_yet", int'(timeout_err), 0);
        @(negedge clkA);
        chk("to_set", int'(timeout_err), 1);
        @(negedge clkA);
        chk("to_next_pulse", int'(sync_pulse), 1);
        chk("to_next_id", int'(sync_id), 1);
        repeat (20) @(negedge clkA);
        chk("to_sticky", int'(timeout_err), 1);
`else
        chk("timeout_tied_0", int'(timeout_err), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_event_arbiter.md
Name: sync_event_arbiter

Overview:
- Shares one clkA->clkB pulse-synchronizer channel among N_REQ single-cycle event sources in the clkA domain, such as MAC status events.
- Queues events per requester in saturating pending counters.
- Picks the next requester round-robin and issues one pulse plus a stable requester ID to the synchronizer.
- Uses the synchronizer's busy feedback as the handshake, so no event is dropped while the channel is in flight.
- Sits between the MAC-core event sources and the pulse synchronizer, on the clkA side.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of sync_id; must satisfy 2**ID_W >= N_REQ.
- CNT_W, 4, width of each per-requester pending counter; saturates at 2**CNT_W-1.
- TIMEOUT, 16, clkA cycles to wait for busy to rise (used only with the optional feature).

Ports:
- clkA  in  1  clock; all logic in this domain.
- rstB  in  1  synchronous, active-high reset.
- evt_in  in  N_REQ  single-cycle event strobes, bit i = requester i.
- sync_busy  in  1  busy feedback from the synchronizer (pulseA_busy).
- ovf_clr  in  N_REQ  write-1-to-clear for the sticky overflow bits.
- sync_pulse  out  1  one-cycle pulse to the synchronizer input (pulseA).
- sync_id  out  ID_W  ID of the requester being transferred; held stable for the whole transfer.
- pending  out  N_REQ  bit i = counter i nonzero.
- ovf  out  N_REQ  sticky; an event was dropped because counter i was saturated.
- timeout_err  out  1  sticky watchdog flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset and clocking: reset is rstB, synchronous, active-high; clock is clkA.
- Reset values:
  - FSM = IDLE.
  - sync_pulse = 0, sync_id = 0.
  - All counters = 0; pending = 0, ovf = 0, timeout_err = 0.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
- Counters, per requester i, evaluated each cycle:
  - evt_in[i] and no grant to i: increment, unless saturated.
  - Grant to i and no evt_in[i]: decrement.
  - Both in the same cycle: counter unchanged.
  - evt_in[i] while saturated and no grant: count unchanged, ovf[i] <= 1.
  - ovf_clr[i] clears ovf[i]; a set event in the same cycle wins.
- Grant: occurs in the cycle the FSM moves IDLE->ISSUE.
  - Winner is the first i with counter != 0, searching from ptr+1 modulo N_REQ.
  - ptr <= winner; sync_id <= winner, registered.
- FSM states:
  - IDLE: if any counter != 0 and sync_busy = 0, grant and go to ISSUE. If sync_busy = 1 (e.g. a transfer still in flight after reset), wait.
  - ISSUE: sync_pulse = 1 for exactly this cycle; go to WAIT_ACK.
  - WAIT_ACK: wait for sync_busy = 1, which normally arrives 1 cycle after the pulse; then go to WAIT_DONE.
  - WAIT_DONE: wait for sync_busy = 0; then go to IDLE.
- Timing:
  - sync_pulse is asserted one cycle after the granting edge, with sync_id already valid.
  - sync_id changes only on a grant, i.e. never while sync_busy = 1 or during WAIT_*.
  - Minimum spacing between pulses is the busy period + 2 cycles (the IDLE decision cycle plus the ISSUE cycle).
- Events arriving during a transfer accumulate and are never lost unless the counter saturates.
- Reset mid-transfer: the FSM returns to IDLE and all counts are dropped. No new pulse is issued until sync_busy is low.
- sync_busy rising while in IDLE: it blocks issue and is otherwise ignored.

Optional Feature:
- Macro SYNC_ARB_TIMEOUT_EN.
- When defined:
  - A watchdog counter clears on entry to WAIT_ACK.
  - If sync_busy has not risen within TIMEOUT cycles, set timeout_err (sticky until reset) and return to IDLE.
  - The granted event is considered consumed and is not retried.
- When undefined: WAIT_ACK waits indefinitely; no watchdog logic is present; timeout_err is tied 0.

Test Plan:
- Reset, then evt_in=0001 for 1 cycle, with a synchronizer model whose busy is high for 6 cycles starting 1 cycle after the pulse:
  - sync_pulse high exactly 1 cycle, 1 cycle after the event is registered, with sync_id=0.
  - pending[0] falls on the grant.
  - No second pulse.
- evt_in=1111 in one cycle:
  - Four pulses with sync_id sequence 0,1,2,3.
  - Each pulse starts at least 2 cycles after busy falls.
  - sync_id is never changed while busy=1.
- Requester 2 given 20 strobes while sync_busy is held 1:
  - Counter saturates at 15; ovf[2]=1.
  - After busy is released, exactly 15 pulses with sync_id=2.
  - ovf_clr[2] then clears ovf[2].
- evt_in[1] asserted in the same cycle as a grant to requester 1 whose counter=1: the counter stays 1 and one more transfer follows.
- rstB asserted during WAIT_DONE with busy still high:
  - All outputs return to reset values.
  - A new event is held until busy=0, then issued.
- With SYNC_ARB_TIMEOUT_EN and TIMEOUT=16, busy tied 0 after a pulse:
  - timeout_err=1 at cycle 16 of WAIT_ACK; FSM back to IDLE.
  - The next pending event is issued normally.
